// File: rtl/updown_counter_modal_pkg.sv
// Shared encodings for the modal up/down counter: boundary modes and FSM states.
package updown_counter_modal_pkg;

  localparam logic [1:0] MODE_WRAP     = 2'd0;
  localparam logic [1:0] MODE_SATURATE = 2'd1;
  localparam logic [1:0] MODE_ONESHOT  = 2'd2;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_t;

endpackage

// File: rtl/ffd_async_reset.sv
// D register with asynchronous active-high reset, reset value and load enable.
module ffd_async_reset #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/updown_counter_modal.sv
// Loadable up/down counter with programmable limit, variable step and
// wrap / saturate / one-shot boundary behaviour.
module updown_counter_modal
  import updown_counter_modal_pkg::*;
#(
  parameter int SIZE        = 16,
  parameter int STEP_WIDTH  = 4,
  parameter int RESET_VALUE = 0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic                  Load,
  input  logic [SIZE-1:0]       LoadValue,
  input  logic [SIZE-1:0]       Limit,
  input  logic [STEP_WIDTH-1:0] Step,
  input  logic                  Direction,
  input  logic [1:0]            Mode,
  output logic [SIZE-1:0]       Q,
  output logic                  TerminalCount,
  output logic                  Done
);

  logic [SIZE-1:0] q_next;
  logic            tc_next;
  state_t          st, st_next;
  logic [0:0]      st_raw;
  logic [SIZE:0]   step_ext, lim_ext, sum;
  logic            hold_mode;

  assign st        = state_t'(st_raw);
  assign step_ext  = (SIZE+1)'(Step);
  assign lim_ext   = {1'b0, Limit};
  assign sum       = {1'b0, Q} + step_ext;
  assign hold_mode = (Mode == MODE_SATURATE) || (Mode == MODE_ONESHOT);

  always_comb begin
    q_next  = Q;
    tc_next = 1'b0;
    st_next = st;
    if (Load) begin
      q_next  = (LoadValue > Limit) ? Limit : LoadValue;
      st_next = RUN;
    end else if (Enable && (st == RUN) && (Step != '0)) begin
      if (Q > Limit) begin
        // Limit was lowered below the current count: snap back into range
        q_next  = Limit;
        tc_next = 1'b1;
      end else if (Direction) begin
        if (sum <= lim_ext) begin
          q_next  = sum[SIZE-1:0];
          tc_next = hold_mode && (sum == lim_ext);
        end else if (!((Mode == MODE_SATURATE) && (Q == Limit))) begin
          q_next  = hold_mode ? Limit : '0;
          tc_next = 1'b1;
        end
      end else begin
        if (step_ext <= {1'b0, Q}) begin
          q_next  = Q - step_ext[SIZE-1:0];
          tc_next = hold_mode && (Q == step_ext[SIZE-1:0]);
        end else if (!((Mode == MODE_SATURATE) && (Q == '0))) begin
          q_next  = hold_mode ? '0 : Limit;
          tc_next = 1'b1;
        end
      end
      if (tc_next && (Mode == MODE_ONESHOT)) st_next = DONE;
    end
  end

  ffd_async_reset #(.W(SIZE), .RST_VAL(SIZE'(RESET_VALUE))) u_q (
    .clk(Clock), .rst(Reset), .en(Load | Enable), .d(q_next), .q(Q)
  );

  ffd_async_reset #(.W(1), .RST_VAL(1'b0)) u_tc (
    .clk(Clock), .rst(Reset), .en(1'b1), .d(tc_next), .q(TerminalCount)
  );

  ffd_async_reset #(.W(1), .RST_VAL(1'b0)) u_done (
    .clk(Clock), .rst(Reset), .en(1'b1), .d(st_next == DONE), .q(Done)
  );

  ffd_async_reset #(.W(1), .RST_VAL(1'b0)) u_state (
    .clk(Clock), .rst(Reset), .en(1'b1), .d(st_next == DONE), .q(st_raw)
  );

endmodule
